i2c_master_seq: RTL and testbench

- I2C master that runs single-byte register transactions against the I2C_trx slave (or any 7-bit-address I2C register device).
- Accepts write and read commands on a valid/ready interface, and sequences START, address, register, data and STOP on open-drain SDA/SCL.
- Returns read data and an error flag as a one-cycle response.
- Sits between local control logic and the Pad_SDA/Pad_SCL pads.

---
 rtl/i2c_master_seq.sv | 204 ++++++++++++++++++++
 tb/tb_i2c_master_seq.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_seq.sv
// Single-byte register I2C master: START, {dev,0}, reg, then wdata or RESTART + {dev,1} + one byte in, STOP.
// Open-drain SDA/SCL enables are registered so the pads never see decode glitches.
module i2c_master_seq #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_START   = 4'd1;
    localparam logic [3:0] S_TX      = 4'd2;
    localparam logic [3:0] S_RACK    = 4'd3;
    localparam logic [3:0] S_RESTART = 4'd4;
    localparam logic [3:0] S_RX      = 4'd5;
    localparam logic [3:0] S_MNACK   = 4'd6;
    localparam logic [3:0] S_STOP    = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    localparam logic [15:0] Q_LAST = 16'(CLK_DIV - 1);

    logic [3:0]  state, nxt_state;
    logic [1:0]  q, nxt_q;
    logic [2:0]  bit_cnt, nxt_bit;
    logic [1:0]  byte_idx, nxt_idx;
    logic [15:0] qcnt;
    logic        on_bus, stall, qtick, accept;
    logic        rw;
    logic [6:0]  dev;
    logic [7:0]  reg_addr, wdata, rx_shift, tx_byte;
    logic        sda_smp, err;
    logic        cell_low, nxt_scl_oe, nxt_sda_oe;

    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign on_bus    = (state != S_IDLE) && (state != S_DONE);
    // A slave holding SCL low freezes the phase timer until the line actually rises.
    assign stall     = on_bus && !scl_oe && !scl_i;
    assign qtick     = on_bus && !stall && (qcnt == Q_LAST);

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        nxt_state = state;
        nxt_q     = q;
        nxt_bit   = bit_cnt;
        nxt_idx   = byte_idx;
        case (state)
            S_IDLE: if (cmd_valid) begin
                nxt_state = S_START;
                nxt_q     = 2'd0;
                nxt_bit   = 3'd0;
                nxt_idx   = 2'd0;
            end
            S_DONE: nxt_state = S_IDLE;
            default: if (qtick) begin
                nxt_q = q + 2'd1;
                case (state)
                    S_START: if (q == 2'd2) begin
                        nxt_state = S_TX;
                        nxt_q     = 2'd0;
                    end
                    S_RESTART: if (q == 2'd3) begin
                        nxt_state = S_TX;
                        nxt_bit   = 3'd0;
                    end
                    S_STOP: if (q == 2'd2) begin
                        nxt_state = S_DONE;
                        nxt_q     = 2'd0;
                    end
                    S_TX, S_RX: if (q == 2'd3) begin
                        nxt_bit = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) nxt_state = (state == S_TX) ? S_RACK : S_MNACK;
                    end
                    S_RACK: if (q == 2'd3) begin
                        if (sda_smp) begin
                            nxt_state = S_STOP;
                        end else begin
                            case (byte_idx)
                                2'd0: begin
                                    nxt_state = S_TX;
                                    nxt_idx   = 2'd1;
                                end
                                2'd1: begin
                                    nxt_state = rw ? S_RESTART : S_TX;
                                    nxt_idx   = 2'd2;
                                end
                                default: nxt_state = rw ? S_RX : S_STOP;
                            endcase
                        end
                    end
                    S_MNACK: if (q == 2'd3) nxt_state = S_STOP;
                    default: ;
                endcase
            end
        endcase
    end

    always_comb begin
        case (nxt_idx)
            2'd0:    tx_byte = {dev, 1'b0};
            2'd1:    tx_byte = reg_addr;
            default: tx_byte = rw ? {dev, 1'b1} : wdata;
        endcase
    end

    // Line drive for the phase being entered; SCL is low in Q0 and Q3 of every bit cell.
    assign cell_low = (nxt_q == 2'd0) || (nxt_q == 2'd3);

    always_comb begin
        nxt_scl_oe = 1'b0;
        nxt_sda_oe = 1'b0;
        case (nxt_state)
            S_START: begin
                nxt_scl_oe = (nxt_q == 2'd2);
                nxt_sda_oe = (nxt_q != 2'd0);
            end
            S_TX: begin
                nxt_scl_oe = cell_low;
                nxt_sda_oe = !tx_byte[3'd7 - nxt_bit];
            end
            S_RACK, S_RX, S_MNACK: nxt_scl_oe = cell_low;
            S_RESTART: begin
                nxt_scl_oe = cell_low;
                nxt_sda_oe = nxt_q[1];
            end
            S_STOP: begin
                nxt_scl_oe = (nxt_q == 2'd0);
                nxt_sda_oe = (nxt_q != 2'd2);
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state     <= S_IDLE;
            q         <= 2'd0;
            bit_cnt   <= 3'd0;
            byte_idx  <= 2'd0;
            qcnt      <= '0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            rw        <= 1'b0;
            dev       <= 7'h00;
            reg_addr  <= 8'h00;
            wdata     <= 8'h00;
            rx_shift  <= 8'h00;
            sda_smp   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= nxt_state;
            q         <= nxt_q;
            bit_cnt   <= nxt_bit;
            byte_idx  <= nxt_idx;
            scl_oe    <= nxt_scl_oe;
            sda_oe    <= nxt_sda_oe;
            rsp_valid <= (nxt_state == S_DONE);
            qcnt      <= (!on_bus || stall || qtick) ? 16'd0 : qcnt + 16'd1;

            if (accept) begin
                rw       <= cmd_rw;
                dev      <= cmd_dev;
                reg_addr <= cmd_reg;
                wdata    <= cmd_wdata;
                rx_shift <= 8'h00;
                sda_smp  <= 1'b0;
                err      <= 1'b0;
                busy     <= 1'b1;
            end

            if (qtick && q == 2'd2) begin
                if (state == S_RACK) sda_smp <= sda_i;
                if (state == S_RX)   rx_shift <= {rx_shift[6:0], sda_i};
            end
            if (qtick && state == S_RACK && q == 2'd3 && sda_smp) err <= 1'b1;

            if (nxt_state == S_DONE && state != S_DONE) begin
                busy      <= 1'b0;
                rsp_err   <= err;
                rsp_rdata <= (rw && !err) ? rx_shift : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_seq.sv
// Self-checking bench: a behavioural I2C slave logs START/STOP/bytes on the resolved bus and
// the log plus each response is compared against the transaction list expected from the command.
module tb_i2c_master_seq;

    localparam int CLK_DIV = 4;
    localparam int EV_S    = 512;
    localparam int EV_P    = 1024;

    logic       clk_50M = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_dev = 7'h00;
    logic [7:0] cmd_reg = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       scl_oe, sda_oe;
    logic       scl_i, sda_i;

    logic       slv_low = 1'b0;
    logic       stretch = 1'b0;
    logic       nack_addr = 1'b0;
    logic [7:0] rd_val = 8'h00;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rsp_n = 0;
    int rsp_cyc = 0;
    logic [7:0] last_rdata;
    logic       last_err, last_busy;

    int log_q[$];
    int exp_q[$];
    int bitn = 0;
    int nbyte = 0;
    bit sending = 0;
    logic [7:0] sh = 8'h00;
    logic prev_scl = 1'b1, prev_sda = 1'b1;

    assign scl_i = !scl_oe && !stretch;
    assign sda_i = !sda_oe && !slv_low;

    i2c_master_seq #(.CLK_DIV(CLK_DIV)) dut (
        .clk_50M  (clk_50M),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_rw   (cmd_rw),
        .cmd_dev  (cmd_dev),
        .cmd_reg  (cmd_reg),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .scl_i    (scl_i),
        .sda_i    (sda_i)
    );

    always #5 clk_50M = ~clk_50M;
    always @(posedge clk_50M) cyc <= cyc + 1;

    always @(negedge clk_50M) begin
        if (rsp_valid) begin
            rsp_n++;
            rsp_cyc    = cyc;
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            last_busy  = busy;
        end
    end

    // Slave: ACKs every byte it receives (except a forced address NACK) and returns rd_val on reads.
    always @(negedge clk_50M) begin
        logic s_scl, s_sda;
        s_scl = scl_i;
        s_sda = sda_i;
        if (rst) begin
            slv_low = 1'b0;
            sending = 0;
            bitn    = 0;
        end else if (s_scl && prev_scl && prev_sda && !s_sda) begin
            log_q.push_back(EV_S);
            bitn = 0; nbyte = 0; sending = 0; slv_low = 1'b0;
        end else if (s_scl && prev_scl && !prev_sda && s_sda) begin
            log_q.push_back(EV_P);
            bitn = 0; sending = 0; slv_low = 1'b0;
        end else if (s_scl && !prev_scl) begin
            if (bitn < 8) sh = {sh[6:0], s_sda};
            else if (bitn == 8) log_q.push_back((s_sda ? 256 : 0) + int'(sh));
            bitn++;
        end else if (!s_scl && prev_scl) begin
            if (bitn == 8) begin
                slv_low = !sending && !(nack_addr && nbyte == 0);
            end else if (bitn == 9) begin
                slv_low = 1'b0;
                bitn = 0;
                if (sending) sending = 0;
                else if (nbyte == 0 && sh[0] && !nack_addr) sending = 1;
                nbyte++;
                if (sending) slv_low = !rd_val[7];
            end else if (sending && bitn >= 1 && bitn <= 7) begin
                slv_low = !rd_val[7 - bitn];
            end
        end
        prev_scl = s_scl;
        prev_sda = s_sda;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the bus transaction list a single-byte register command must produce.
    task automatic build_exp(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                             input logic [7:0] wd, input logic nack, input logic [7:0] rdv);
        exp_q.delete();
        exp_q.push_back(EV_S);
        if (nack) begin
            exp_q.push_back(256 + int'({dev, 1'b0}));
        end else begin
            exp_q.push_back(int'({dev, 1'b0}));
            exp_q.push_back(int'(rg));
            if (rw) begin
                exp_q.push_back(EV_S);
                exp_q.push_back(int'({dev, 1'b1}));
                exp_q.push_back(256 + int'(rdv));
            end else begin
                exp_q.push_back(int'(wd));
            end
        end
        exp_q.push_back(EV_P);
    endtask

    task automatic compare_log(input string tag, input int base);
        check({tag, "_log_len"}, log_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < log_q.size())
                check($sformatf("%s_ev%0d", tag, i), log_q[base + i], exp_q[i]);
    endtask

    task automatic wait_rsp(input int n0, input string tag);
        int t = 0;
        while (!rsp_valid && t < 4000) begin
            @(negedge clk_50M);
            t++;
        end
        repeat (3) @(negedge clk_50M);
        check({tag, "_rsp_count"}, rsp_n, n0 + 1);
    endtask

    task automatic check_rsp(input string tag, input logic rw, input logic nack, input logic [7:0] rdv);
        check({tag, "_err"}, last_err, nack);
        check({tag, "_rdata"}, last_rdata, (rw && !nack) ? rdv : 8'h00);
        check({tag, "_busy_at_rsp"}, last_busy, 1'b0);
    endtask

    task automatic do_cmd(input string tag, input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd, input logic nack, input logic [7:0] rdv);
        int n0, base, acc, lat;
        int wr_lat = (3 + 27 * 4 + 3) * CLK_DIV;
        nack_addr = nack;
        rd_val    = rdv;
        base      = log_q.size();
        n0        = rsp_n;
        @(negedge clk_50M);
        cmd_rw = rw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd; cmd_valid = 1'b1;
        check({tag, "_ready_idle"}, cmd_ready, 1'b1);
        @(posedge clk_50M); #1;
        acc = cyc;
        check({tag, "_busy_after_accept"}, busy, 1'b1);
        check({tag, "_ready_busy"}, cmd_ready, 1'b0);
        @(negedge clk_50M);
        cmd_valid = 1'b0;
        wait_rsp(n0, tag);
        build_exp(rw, dev, rg, wd, nack, rdv);
        compare_log(tag, base);
        check_rsp(tag, rw, nack, rdv);
        if (!rw && !nack) begin
            lat = rsp_cyc - acc;
            check({tag, "_latency"}, (lat >= wr_lat - 1 && lat <= wr_lat + 1) ? wr_lat : lat, wr_lat);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int base, n0, t, bad, n;

        repeat (3) @(posedge clk_50M);
        #1;
        check("rst_scl_oe", scl_oe, 1'b0);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 8'h00);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk_50M);
        rst = 1'b0;
        repeat (2) @(negedge clk_50M);

        do_cmd("write", 1'b0, 7'h50, 8'h03, 8'hA5, 1'b0, 8'h00);
        do_cmd("read", 1'b1, 7'h50, 8'h05, 8'h00, 1'b0, 8'h3C);
        do_cmd("addr_nack", 1'b0, 7'h50, 8'h03, 8'hA5, 1'b1, 8'h00);
        do_cmd("addr_nack_rd", 1'b1, 7'h50, 8'h05, 8'h00, 1'b1, 8'h3C);

        // Clock stretch during Q1 of bit 4 of the register byte.
        nack_addr = 1'b0;
        base = log_q.size();
        n0 = rsp_n;
        @(negedge clk_50M);
        cmd_rw = 1'b0; cmd_dev = 7'h50; cmd_reg = 8'hC6; cmd_wdata = 8'h3B; cmd_valid = 1'b1;
        @(posedge clk_50M); #1;
        @(negedge clk_50M);
        cmd_valid = 1'b0;
        t = 0;
        while (!(nbyte == 1 && bitn == 4 && scl_oe) && t < 4000) begin
            @(negedge clk_50M);
            t++;
        end
        check("stretch_arm_byte", nbyte, 1);
        check("stretch_arm_bit", bitn, 4);
        stretch = 1'b1;
        t = 0;
        while (scl_oe && t < 4000) begin
            @(negedge clk_50M);
            t++;
        end
        bad = 0;
        repeat (500) begin
            @(negedge clk_50M);
            if (scl_oe !== 1'b0) bad++;
        end
        check("stretch_hold", bad, 0);
        stretch = 1'b0;
        n = 0;
        do begin
            @(posedge clk_50M); #1;
            n++;
        end while (!scl_oe && n < 1000);
        check("stretch_q1q2_len", n, 2 * CLK_DIV);
        wait_rsp(n0, "stretch");
        build_exp(1'b0, 7'h50, 8'hC6, 8'h3B, 1'b0, 8'h00);
        compare_log("stretch", base);
        check_rsp("stretch", 1'b0, 1'b0, 8'h00);

        // Reset during the data byte.
        n0 = rsp_n;
        @(negedge clk_50M);
        cmd_rw = 1'b0; cmd_dev = 7'h2A; cmd_reg = 8'h11; cmd_wdata = 8'h00; cmd_valid = 1'b1;
        @(posedge clk_50M); #1;
        @(negedge clk_50M);
        cmd_valid = 1'b0;
        t = 0;
        while (!(nbyte == 2 && bitn == 3) && t < 4000) begin
            @(negedge clk_50M);
            t++;
        end
        check("midrst_reached_data", nbyte, 2);
        rst = 1'b1;
        @(posedge clk_50M); #1;
        check("midrst_scl_oe", scl_oe, 1'b0);
        check("midrst_sda_oe", sda_oe, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        @(negedge clk_50M);
        rst = 1'b0;
        repeat (20) @(negedge clk_50M);
        check("midrst_no_rsp", rsp_n, n0);
        do_cmd("post_rst_write", 1'b0, 7'h2A, 8'h11, 8'hE7, 1'b0, 8'h00);

        // Back-to-back: cmd_valid held high across two commands.
        nack_addr = 1'b0;
        rd_val = 8'h96;
        base = log_q.size();
        n0 = rsp_n;
        @(negedge clk_50M);
        cmd_rw = 1'b0; cmd_dev = 7'h22; cmd_reg = 8'h10; cmd_wdata = 8'h5A; cmd_valid = 1'b1;
        @(posedge clk_50M); #1;
        @(negedge clk_50M);
        cmd_rw = 1'b1; cmd_reg = 8'h11; cmd_wdata = 8'h00;
        bad = 0; t = 0;
        while (!rsp_valid && t < 4000) begin
            if (cmd_ready !== 1'b0) bad++;
            @(negedge clk_50M);
            t++;
        end
        check("b2b_ready_low_while_busy", bad, 0);
        check("b2b_ready_at_rsp", cmd_ready, 1'b0);
        @(negedge clk_50M);
        check("b2b_ready_after_rsp", cmd_ready, 1'b1);
        @(posedge clk_50M); #1;
        check("b2b_second_accept", busy, 1'b1);
        @(negedge clk_50M);
        cmd_valid = 1'b0;
        check("b2b_first_rsp_count", rsp_n, n0 + 1);
        build_exp(1'b0, 7'h22, 8'h10, 8'h5A, 1'b0, 8'h00);
        compare_log("b2b_first", base);
        check_rsp("b2b_first", 1'b0, 1'b0, 8'h00);
        base = log_q.size();
        n0 = rsp_n;
        wait_rsp(n0, "b2b_second");
        build_exp(1'b1, 7'h22, 8'h11, 8'h00, 1'b0, 8'h96);
        compare_log("b2b_second", base);
        check_rsp("b2b_second", 1'b1, 1'b0, 8'h96);

        for (int i = 0; i < 6; i++) begin
            do_cmd($sformatf("rand%0d", i), 1'($urandom), 7'($urandom), 8'($urandom),
                   8'($urandom), 1'($urandom_range(0, 3) == 0), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
